// File: rtl/tour_cmd.sv
// Replays the stored knight's-tour moves as vertical/horizontal drive commands and
// muxes them with UART-sourced commands into the command processor.
module tour_cmd #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] VERT   = 3'd1;
   localparam logic [2:0] HOLD_V = 3'd2;
   localparam logic [2:0] HORZ   = 3'd3;
   localparam logic [2:0] HOLD_H = 3'd4;

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   localparam logic [7:0] HEAD_N = 8'h00;
   localparam logic [7:0] HEAD_W = 8'h3F;
   localparam logic [7:0] HEAD_S = 8'h7F;
   localparam logic [7:0] HEAD_E = 8'hBF;

   logic [2:0]  state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic        dx_neg, dy_neg;
   logic [1:0]  dx_mag, dy_mag;
   logic [15:0] vert_cmd, horz_cmd;

   // Lowest set bit wins; an all-zero move decodes to a zero-length north/east pair.
   always_comb begin
      dx_neg = 1'b0;
      dy_neg = 1'b0;
      dx_mag = 2'd0;
      dy_mag = 2'd0;
      casez (move)
         8'b???????1: begin dx_mag = 2'd1; dy_mag = 2'd2; end
         8'b??????10: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_mag = 2'd2; end
         8'b?????100: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_mag = 2'd1; end
         8'b????1000: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
         8'b???10000: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
         8'b??100000: begin dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
         8'b?1000000: begin dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
         8'b10000000: begin dx_mag = 2'd2; dy_mag = 2'd1; end
         default: ;
      endcase
   end

   assign vert_cmd = {4'b0010, (dy_neg ? HEAD_S : HEAD_N), 2'b00, dy_mag};
   assign horz_cmd = {4'b0011, (dx_neg ? HEAD_W : HEAD_E), 2'b00, dx_mag};

   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      case (state_q)
         IDLE: begin
            if (start_tour) begin
               state_d   = VERT;
               mv_indx_d = 5'd0;
            end
         end
         VERT:   if (clr_cmd_rdy) state_d = HOLD_V;
         HOLD_V: if (send_resp)   state_d = HORZ;
         HORZ:   if (clr_cmd_rdy) state_d = HOLD_H;
         HOLD_H: begin
            if (send_resp) begin
               if (mv_indx_q == LAST_INDX) begin
                  state_d = IDLE;
               end else begin
                  state_d   = VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   // UART owns the command path only while no tour is being replayed.
   always_comb begin
      cmd              = vert_cmd;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      case (state_q)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
         end
         VERT:   begin cmd = vert_cmd; cmd_rdy = 1'b1; end
         HOLD_V: cmd = vert_cmd;
         HORZ:   begin cmd = horz_cmd; cmd_rdy = 1'b1; end
         HOLD_H: cmd = horz_cmd;
         default: ;
      endcase
   end

   assign resp    = ((state_q != IDLE) && (mv_indx_q == LAST_INDX)) ? 8'h5A : 8'hA5;
   assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Bench for tour_cmd: directed literal checks plus randomized handshakes compared
// every cycle against a tour-level reference model.
module tb_tour_cmd;

   localparam int NUM_MOVES = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;

   logic [7:0]  tour_mem [NUM_MOVES];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 1'b0;

   // Reference model: touring flag, move index, which leg (0 vertical, 1 horizontal),
   // and whether the current leg's command has been taken by the processor.
   bit          m_tour;
   int          m_idx;
   int          m_leg;
   bit          m_taken;

   tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
      .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
      .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
   );

   always #5 clk = ~clk;

   assign move = (mv_indx < 5'(NUM_MOVES)) ? tour_mem[mv_indx] : 8'h00;

   function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input int leg);
      int b = -1;
      int dx = 0;
      int dy = 0;
      int mag;
      for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
      case (b)
         0: begin dx =  1; dy =  2; end
         1: begin dx = -1; dy =  2; end
         2: begin dx = -2; dy =  1; end
         3: begin dx = -2; dy = -1; end
         4: begin dx = -1; dy = -2; end
         5: begin dx =  1; dy = -2; end
         6: begin dx =  2; dy = -1; end
         7: begin dx =  2; dy =  1; end
         default: begin dx = 0; dy = 0; end
      endcase
      if (leg == 0) begin
         mag = (dy < 0) ? -dy : dy;
         return {4'h2, ((dy < 0) ? 8'h7F : 8'h00), 4'(mag)};
      end
      mag = (dx < 0) ? -dx : dx;
      return {4'h3, ((dx < 0) ? 8'h3F : 8'hBF), 4'(mag)};
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit st, input bit clr, input bit sr);
      start_tour  = st;
      clr_cmd_rdy = clr;
      send_resp   = sr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doLeg();
      applyStimulus(0, 1, 0);
      tick();
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      #1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tour  = 1'b0;
         m_idx   = 0;
         m_leg   = 0;
         m_taken = 1'b0;
      end else if (!m_tour) begin
         if (start_tour) begin
            m_tour  = 1'b1;
            m_idx   = 0;
            m_leg   = 0;
            m_taken = 1'b0;
         end
      end else if (!m_taken) begin
         if (clr_cmd_rdy) m_taken = 1'b1;
      end else if (send_resp) begin
         m_taken = 1'b0;
         if (m_leg == 0) begin
            m_leg = 1;
         end else begin
            m_leg = 0;
            if (m_idx == NUM_MOVES - 1) m_tour = 1'b0;
            else m_idx++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("mv_indx", {11'b0, mv_indx}, 16'(m_idx));
         if (!m_tour) begin
            checkOutput("idle cmd", cmd, cmd_UART);
            checkOutput("idle cmd_rdy", {15'b0, cmd_rdy}, {15'b0, cmd_rdy_UART});
            checkOutput("idle clr_uart", {15'b0, clr_cmd_rdy_UART}, {15'b0, clr_cmd_rdy});
            checkOutput("idle resp", {8'b0, resp}, 16'h00A5);
         end else begin
            checkOutput("tour cmd_rdy", {15'b0, cmd_rdy}, {15'b0, !m_taken});
            if (!m_taken) checkOutput("tour cmd", cmd, leg_cmd(tour_mem[m_idx], m_leg));
            checkOutput("tour clr_uart", {15'b0, clr_cmd_rdy_UART}, 16'h0000);
            checkOutput("tour resp", {8'b0, resp}, (m_idx == NUM_MOVES - 1) ? 16'h005A : 16'h00A5);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      cmd_UART     = 16'h0000;
      cmd_rdy_UART = 1'b0;
      applyStimulus(0, 0, 0);
      for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << $urandom_range(7);
      tour_mem[0] = 8'h01;
      tour_mem[1] = 8'h08;
      tour_mem[2] = 8'h40;
      tour_mem[3] = 8'h00;
      chk_en = 1'b1;
      #23 rst_n = 1'b1;
      tick();
      checkOutput("reset mv_indx", {11'b0, mv_indx}, 16'h0000);
      checkOutput("reset resp", {8'b0, resp}, 16'h00A5);

      cmd_UART = 16'h2BF1;
      cmd_rdy_UART = 1'b1;
      applyStimulus(0, 1, 0);
      #1;
      checkOutput("pass cmd", cmd, 16'h2BF1);
      checkOutput("pass cmd_rdy", {15'b0, cmd_rdy}, 16'h0001);
      checkOutput("pass clr_uart hi", {15'b0, clr_cmd_rdy_UART}, 16'h0001);
      checkOutput("pass resp", {8'b0, resp}, 16'h00A5);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("pass clr_uart lo", {15'b0, clr_cmd_rdy_UART}, 16'h0000);

      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("b0 vert", cmd, 16'h2002);
      checkOutput("b0 vert rdy", {15'b0, cmd_rdy}, 16'h0001);
      applyStimulus(0, 1, 0);
      #1;
      checkOutput("tour clr_uart blocked", {15'b0, clr_cmd_rdy_UART}, 16'h0000);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("hold_v rdy", {15'b0, cmd_rdy}, 16'h0000);
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("b0 horz", cmd, 16'h3BF1);
      doLeg();
      checkOutput("advance mv_indx", {11'b0, mv_indx}, 16'h0001);
      checkOutput("b3 vert", cmd, 16'h27F1);
      doLeg();
      checkOutput("b3 horz", cmd, 16'h33F2);
      doLeg();
      checkOutput("b6 vert", cmd, 16'h27F1);
      doLeg();
      checkOutput("b6 horz", cmd, 16'h3BF2);
      doLeg();
      checkOutput("zero vert", cmd, 16'h2000);
      doLeg();
      checkOutput("zero horz", cmd, 16'h3BF0);
      doLeg();

      applyStimulus(0, 0, 1);
      tick();
      checkOutput("sr in vert ignored", {15'b0, cmd_rdy}, 16'h0001);
      applyStimulus(0, 1, 1);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("clr+sr to hold_v", {15'b0, cmd_rdy}, 16'h0000);
      tick();
      checkOutput("still hold_v", {15'b0, cmd_rdy}, 16'h0000);
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("start mid-tour", {11'b0, mv_indx}, 16'h0004);
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      #1;
      checkOutput("late sr to horz", {15'b0, cmd_rdy}, 16'h0001);
      doLeg();
      for (int i = 5; i < NUM_MOVES; i++) begin
         checkOutput("tour index", {11'b0, mv_indx}, 16'(i));
         checkOutput("resp vert", {8'b0, resp}, (i == NUM_MOVES - 1) ? 16'h005A : 16'h00A5);
         doLeg();
         checkOutput("resp horz", {8'b0, resp}, (i == NUM_MOVES - 1) ? 16'h005A : 16'h00A5);
         doLeg();
      end
      cmd_UART = 16'h1234;
      cmd_rdy_UART = 1'b0;
      #1;
      checkOutput("end mv_indx", {11'b0, mv_indx}, 16'h0017);
      checkOutput("end resp", {8'b0, resp}, 16'h00A5);
      checkOutput("end pass cmd", cmd, 16'h1234);
      checkOutput("end pass rdy", {15'b0, cmd_rdy}, 16'h0000);

      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         doLeg();
         doLeg();
      end
      doLeg();
      checkOutput("pre-reset mv_indx", {11'b0, mv_indx}, 16'h0007);
      checkOutput("pre-reset horz rdy", {15'b0, cmd_rdy}, 16'h0001);
      cmd_UART = 16'hBEEF;
      applyStimulus(0, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst mv_indx", {11'b0, mv_indx}, 16'h0000);
      checkOutput("rst cmd", cmd, 16'hBEEF);
      checkOutput("rst cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
      checkOutput("rst clr_uart", {15'b0, clr_cmd_rdy_UART}, 16'h0001);
      checkOutput("rst resp", {8'b0, resp}, 16'h00A5);
      applyStimulus(0, 0, 0);
      #4 rst_n = 1'b1;
      tick();

      for (int i = 0; i < NUM_MOVES; i++) begin
         if ($urandom_range(3) != 0) tour_mem[i] = 8'h01 << $urandom_range(7);
         else tour_mem[i] = 8'($urandom);
      end
      for (int c = 0; c < 3000; c++) begin
         cmd_UART     = 16'($urandom);
         cmd_rdy_UART = 1'($urandom);
         applyStimulus(($urandom_range(15) == 0), 1'($urandom), 1'($urandom));
         if ($urandom_range(499) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
         tick();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Consumer end of the knight's-tour move store.
- After the solver finishes, this block walks the stored one-hot moves by index (mv_indx -> move) and turns each move into two drive commands: a vertical leg, then a horizontal leg with fanfare.
- It muxes these commands with UART-sourced commands into the command processor using the cmd_rdy / clr_cmd_rdy / send_resp handshake.

Parameters:
NUM_MOVES, 24, number of moves replayed per tour (indices 0..NUM_MOVES-1).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start_tour  in  1  one-cycle pulse; begin replaying moves from index 0.
move  in  8  one-hot move at mv_indx, from the tour solver store.
mv_indx  out  5  index of the move currently being replayed.
cmd_UART  in  16  command from UART wrapper.
cmd_rdy_UART  in  1  UART command valid.
clr_cmd_rdy_UART  out  1  acknowledge to UART wrapper.
clr_cmd_rdy  in  1  command processor has taken cmd.
send_resp  in  1  command processor finished executing the current cmd.
cmd  out  16  command to command processor.
cmd_rdy  out  1  cmd valid.
resp  out  8  response byte to host.

Behaviour:
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcode 4'b0010 = move; 4'b0011 = move with fanfare.
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Move decode, bit -> (dx,dy), +x east, +y north:
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1).
  - Non-one-hot input: lowest set bit wins.
  - move==0: vertical cmd heading north, 0 squares; horizontal cmd heading east, 0 squares.
- Vertical cmd: opcode 0010, heading north if dy>0 else south, squares=|dy|.
- Horizontal cmd: opcode 0011, heading east if dx>0 else west, squares=|dx|.
- State machine: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: start_tour -> VERT; mv_indx<=0. Other inputs ignored for state.
  - VERT: cmd=vertical cmd, cmd_rdy=1. On clr_cmd_rdy -> HOLD_V. send_resp in VERT is ignored, including when it coincides with clr_cmd_rdy.
  - HOLD_V: cmd_rdy=0. On send_resp -> HORZ.
  - HORZ: cmd=horizontal cmd, cmd_rdy=1. On clr_cmd_rdy -> HOLD_H.
  - HOLD_H: cmd_rdy=0. On send_resp:
    - if mv_indx==NUM_MOVES-1 -> IDLE, mv_indx held;
    - else mv_indx<=mv_indx+1 -> VERT.
- Mux:
  - In IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - In any other state: clr_cmd_rdy_UART=0 and UART inputs are ignored.
- cmd / cmd_rdy / clr_cmd_rdy_UART are combinational from state, registered mv_indx and inputs. move must be stable while mv_indx is stable (solver store is combinational read).
- resp:
  - 8'h5A when not in IDLE and mv_indx==NUM_MOVES-1;
  - 8'hA5 otherwise, including in IDLE.
- start_tour while not IDLE: ignored.
- Reset (any time, incl. mid-tour): state=IDLE, mv_indx=0.
  - Outputs then follow passthrough: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- Latency:
  - cmd_rdy rises the cycle after start_tour, and the cycle after send_resp in HOLD_V/HOLD_H.
  - cmd_rdy falls the cycle after clr_cmd_rdy.

Test Plan:
- Passthrough: IDLE, cmd_UART=16'h2BF1, cmd_rdy_UART=1, pulse clr_cmd_rdy -> cmd=16'h2BF1, cmd_rdy=1, clr_cmd_rdy_UART mirrors the pulse, resp=8'hA5.
- Single move b0: start_tour, move=8'h01 -> cmd=16'h2002, cmd_rdy=1. After clr_cmd_rdy + send_resp -> cmd=16'h3BF1. After clr + send_resp -> mv_indx=1, state VERT.
- Decode sweep:
  - move=8'h08 -> 16'h27F1 then 16'h33F2;
  - move=8'h40 -> 16'h27F1 then 16'h3BF2;
  - move=8'h00 -> 16'h2000 then 16'h3BF0.
- Full tour: 24 moves with handshakes -> mv_indx 0..23 in order, resp=8'h5A only during index 23, IDLE after the final send_resp with mv_indx=23, passthrough resumes.
- Protocol corners:
  - send_resp in VERT, or coincident with clr_cmd_rdy -> no advance past HOLD_V until a later send_resp.
  - start_tour mid-tour -> mv_indx unchanged.
- Reset mid-tour at mv_indx=7 in HORZ: assert rst_n=0 asynchronously -> immediately IDLE, mv_indx=0, passthrough outputs, resp=8'hA5.
